// File: rtl/crypto_stream_ctrl_pkg.sv
// Shared types and nibble/keystream helpers for the byte cipher frame sequencer.
package crypto_pkg;

  localparam logic [7:0] SEED_DEFAULT = 8'hAC;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    FIN   = 2'd3
  } state_e;

  function automatic logic [3:0] sbox(input logic [3:0] n);
    case (n)
      4'h0: sbox = 4'h6;
      4'h1: sbox = 4'h4;
      4'h2: sbox = 4'hC;
      4'h3: sbox = 4'h5;
      4'h4: sbox = 4'h0;
      4'h5: sbox = 4'h7;
      4'h6: sbox = 4'h2;
      4'h7: sbox = 4'hE;
      4'h8: sbox = 4'h1;
      4'h9: sbox = 4'hF;
      4'hA: sbox = 4'h3;
      4'hB: sbox = 4'hD;
      4'hC: sbox = 4'h8;
      4'hD: sbox = 4'hA;
      4'hE: sbox = 4'h9;
      4'hF: sbox = 4'hB;
      default: sbox = 4'h0;
    endcase
  endfunction

  function automatic logic [3:0] inv_sbox(input logic [3:0] n);
    case (n)
      4'h0: inv_sbox = 4'h4;
      4'h1: inv_sbox = 4'h8;
      4'h2: inv_sbox = 4'h6;
      4'h3: inv_sbox = 4'hA;
      4'h4: inv_sbox = 4'h1;
      4'h5: inv_sbox = 4'h3;
      4'h6: inv_sbox = 4'h0;
      4'h7: inv_sbox = 4'h5;
      4'h8: inv_sbox = 4'hC;
      4'h9: inv_sbox = 4'hE;
      4'hA: inv_sbox = 4'hD;
      4'hB: inv_sbox = 4'hF;
      4'hC: inv_sbox = 4'h2;
      4'hD: inv_sbox = 4'hB;
      4'hE: inv_sbox = 4'h7;
      4'hF: inv_sbox = 4'h9;
      default: inv_sbox = 4'h0;
    endcase
  endfunction

  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    lfsr_next = {s[6:0], s[7] ^ s[6] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

endpackage

// File: rtl/crypto_stream_ctrl_if.sv
// Input and output byte streams of the cipher sequencer; slave is the sequencer side.
interface crypto_stream_ctrl_if;
  logic       s_valid;
  logic       s_ready;
  logic [7:0] s_data;
  logic       m_valid;
  logic       m_ready;
  logic [7:0] m_data;
  logic       m_last;

  modport slave (
    input  s_valid, s_data, m_ready,
    output s_ready, m_valid, m_data, m_last
  );

  modport master (
    output s_valid, s_data, m_ready,
    input  s_ready, m_valid, m_data, m_last
  );
endinterface

// File: rtl/crypto_stream_ctrl_xform.sv
// Combinational single-byte cipher: XOR/rotate/S-box forward, exact inverse when mode = 1.
module crypto_byte_xform
  import crypto_pkg::*;
(
  input  logic [7:0] d,
  input  logic [7:0] key,
  input  logic       mode,
  output logic [7:0] dout
);

  logic [7:0] enc_x_s;
  logic [7:0] enc_r_s;
  logic [7:0] dec_y_s;
  logic [7:0] dec_r_s;

  // Both directions are built in parallel; mode only picks the result.
  always_comb begin
    enc_x_s = d ^ key;
    enc_r_s = {enc_x_s[6:0], enc_x_s[7]};
    dec_y_s = {inv_sbox(d[7:4]), inv_sbox(d[3:0])};
    dec_r_s = {dec_y_s[0], dec_y_s[7:1]};
    if (mode) begin
      dout = dec_r_s ^ key;
    end else begin
      dout = {sbox(enc_r_s[7:4]), sbox(enc_r_s[3:0])};
    end
  end

endmodule

// File: rtl/crypto_stream_ctrl.sv
// Frame sequencer: accepts cfg_len bytes, transforms each with a per-frame reseeded
// keystream that advances once per accepted byte, and emits a registered output stream.
module crypto_stream_ctrl
  import crypto_pkg::state_e;
  import crypto_pkg::IDLE;
  import crypto_pkg::RUN;
  import crypto_pkg::DRAIN;
  import crypto_pkg::FIN;
  import crypto_pkg::lfsr_next;
#(
  parameter int         LEN_W        = 16,
  parameter logic [7:0] SEED_DEFAULT = crypto_pkg::SEED_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 cfg_mode,
  input  logic [7:0]           cfg_seed,
  input  logic [LEN_W-1:0]     cfg_len,
  crypto_stream_ctrl_if.slave  bus,
  output logic                 busy,
  output logic                 done,
  output logic [LEN_W-1:0]     byte_cnt
);

  localparam logic [LEN_W-1:0] CNT_ZERO = {LEN_W{1'b0}};
  localparam logic [LEN_W-1:0] CNT_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic             mode_q, mode_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [7:0]       lfsr_q, lfsr_d;
  logic             m_valid_q, m_valid_d;
  logic [7:0]       m_data_q, m_data_d;
  logic             m_last_q, m_last_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             s_ready_s;
  logic             in_hs_s;
  logic             last_byte_s;
  logic [7:0]       xform_s;

  crypto_byte_xform u_xform (
    .d    (bus.s_data),
    .key  (lfsr_q),
    .mode (mode_q),
    .dout (xform_s)
  );

  // s_ready follows m_ready combinationally so a full-rate stream sees no bubble;
  // the count guard keeps the frame from ever taking more than len bytes.
  assign s_ready_s   = (state_q == RUN) && (cnt_q != len_q) && (!m_valid_q || bus.m_ready);
  assign in_hs_s     = s_ready_s && bus.s_valid;
  assign last_byte_s = (cnt_q == (len_q - CNT_ONE));

  // Next-state and next-output computation for the frame FSM.
  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    lfsr_d    = lfsr_q;
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    m_last_d  = m_last_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          cnt_d = CNT_ZERO;
          if (cfg_len != CNT_ZERO) begin
            mode_d  = cfg_mode;
            len_d   = cfg_len;
            lfsr_d  = cfg_seed;
            state_d = RUN;
          end else begin
            state_d = FIN;
          end
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (in_hs_s) begin
          m_data_d  = xform_s;
          m_valid_d = 1'b1;
          m_last_d  = last_byte_s;
          lfsr_d    = lfsr_next(lfsr_q);
          cnt_d     = cnt_q + CNT_ONE;
          if (last_byte_s) begin
            state_d = DRAIN;
          end else begin
            state_d = RUN;
          end
        end else if (bus.m_ready) begin
          m_valid_d = 1'b0;
          m_last_d  = 1'b0;
        end else begin
          m_valid_d = m_valid_q;
        end
      end
      DRAIN: begin
        if (m_valid_q && bus.m_ready) begin
          m_valid_d = 1'b0;
          m_last_d  = 1'b0;
          state_d   = FIN;
        end else begin
          state_d = DRAIN;
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == FIN);
  end

  // State and output registers; reset aborts any frame without a done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      mode_q    <= 1'b0;
      len_q     <= CNT_ZERO;
      cnt_q     <= CNT_ZERO;
      lfsr_q    <= SEED_DEFAULT;
      m_valid_q <= 1'b0;
      m_data_q  <= 8'h00;
      m_last_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      lfsr_q    <= lfsr_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      m_last_q  <= m_last_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bus.s_ready = s_ready_s;
  assign bus.m_valid = m_valid_q;
  assign bus.m_data  = m_data_q;
  assign bus.m_last  = m_last_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign byte_cnt    = cnt_q;

endmodule

// File: tb/tb_crypto_stream_ctrl.sv
// Self-checking bench for crypto_stream_ctrl: vector table, directed corner sequences
// and randomized frames scored against a behavioural cipher model.
module tb_crypto_stream_ctrl;

  localparam int LEN_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             cfg_mode;
  logic [7:0]       cfg_seed;
  logic [LEN_W-1:0] cfg_len;
  logic             busy;
  logic             done;
  logic [LEN_W-1:0] byte_cnt;

  crypto_stream_ctrl_if bus ();

  crypto_stream_ctrl #(.LEN_W(LEN_W), .SEED_DEFAULT(8'hAC)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .cfg_mode (cfg_mode),
    .cfg_seed (cfg_seed),
    .cfg_len  (cfg_len),
    .bus      (bus),
    .busy     (busy),
    .done     (done),
    .byte_cnt (byte_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  localparam logic [3:0] SB [16] = '{4'h6, 4'h4, 4'hC, 4'h5, 4'h0, 4'h7, 4'h2, 4'hE,
                                     4'h1, 4'hF, 4'h3, 4'hD, 4'h8, 4'hA, 4'h9, 4'hB};

  function automatic logic [3:0] m_isb(input logic [3:0] v);
    for (int i = 0; i < 16; i++) if (SB[i] == v) return 4'(i);
    return 4'h0;
  endfunction

  function automatic logic [7:0] m_enc(input logic [7:0] d, input logic [7:0] k);
    int x;
    x = int'(d ^ k);
    x = ((x << 1) | (x >> 7)) & 255;
    return {SB[x / 16], SB[x % 16]};
  endfunction

  function automatic logic [7:0] m_dec(input logic [7:0] d, input logic [7:0] k);
    int y;
    y = int'(m_isb(d[7:4])) * 16 + int'(m_isb(d[3:0]));
    y = ((y >> 1) | (y << 7)) & 255;
    return 8'(y) ^ k;
  endfunction

  function automatic logic [7:0] m_step(input logic [7:0] k);
    return {k[6:0], ^k[7:3]};
  endfunction

  // ---------------- frame driver / scoreboard ----------------
  logic [7:0] frame_data[$];
  logic [7:0] got_data[$];
  logic       got_last[$];
  int         in_cyc[$];
  int         out_cyc[$];

  task automatic run_frame(input logic mode, input logic [7:0] seed, input int len,
                           input int rdy_pct, input int vld_pct, input int stall_at,
                           input bit junk_start);
    logic [7:0] exp_d[$];
    logic [7:0] key;
    int in_idx, out_idx, cyc, last_out_cyc, bound;
    bit seen_done, pv_stall;
    logic [7:0] pv_data, pv_lfsr;
    logic pv_last;
    key = seed;
    for (int i = 0; i < len; i++) begin
      exp_d.push_back(mode ? m_dec(frame_data[i], key) : m_enc(frame_data[i], key));
      key = m_step(key);
    end
    got_data.delete(); got_last.delete(); in_cyc.delete(); out_cyc.delete();
    in_idx = 0; out_idx = 0; cyc = 0; last_out_cyc = -10; seen_done = 1'b0; pv_stall = 1'b0;
    pv_data = 8'h00; pv_lfsr = 8'h00; pv_last = 1'b0;
    bound = 20 * len + 100;

    @(negedge clk);
    start = 1'b1; cfg_mode = mode; cfg_seed = seed; cfg_len = LEN_W'(len);
    bus.s_valid = 1'b0; bus.m_ready = 1'b1;
    @(negedge clk);
    start = junk_start;
    chk("busy_in_frame", busy, 1'b1);
    while (cyc < bound) begin
      if (pv_stall) begin
        chk("stall_m_valid", bus.m_valid, 1'b1);
        chk("stall_m_data", bus.m_data, pv_data);
        chk("stall_m_last", bus.m_last, pv_last);
        chk("stall_lfsr", dut.lfsr_q, pv_lfsr);
      end
      if (done) begin
        seen_done = 1'b1;
        start = 1'b0;
        chk("done_after_all_out", out_idx, len);
        chk("done_latency", cyc - last_out_cyc, 1);
        break;
      end
      if (junk_start) begin
        cfg_mode = 1'($urandom); cfg_seed = 8'($urandom); cfg_len = LEN_W'($urandom_range(9));
      end
      bus.m_ready = (cyc >= stall_at && cyc < stall_at + 5) ? 1'b0
                    : ($urandom_range(99) < rdy_pct);
      if (in_idx < len) begin
        bus.s_valid = ($urandom_range(99) < vld_pct);
        bus.s_data  = frame_data[in_idx];
      end else begin
        bus.s_valid = 1'($urandom_range(1));
        bus.s_data  = 8'($urandom);
      end
      #1;
      if (bus.m_valid && bus.m_ready) begin
        if (out_idx < len) begin
          chk("m_data", bus.m_data, exp_d[out_idx]);
          chk("m_last", bus.m_last, (out_idx == len - 1));
        end else begin
          chk("extra_output", out_idx, len - 1);
        end
        got_data.push_back(bus.m_data);
        got_last.push_back(bus.m_last);
        out_cyc.push_back(cyc);
        last_out_cyc = cyc;
        out_idx++;
      end
      if (bus.m_valid && !bus.m_ready) chk("stall_s_ready", bus.s_ready, 1'b0);
      if (bus.s_valid && bus.s_ready) begin
        if (in_idx >= len) chk("over_accept", in_idx, len - 1);
        in_cyc.push_back(cyc);
        in_idx++;
      end
      pv_stall = bus.m_valid && !bus.m_ready;
      pv_data = bus.m_data; pv_last = bus.m_last; pv_lfsr = dut.lfsr_q;
      @(negedge clk);
      cyc++;
    end
    start = 1'b0; bus.s_valid = 1'b0; bus.m_ready = 1'b0;
    if (!seen_done) chk("frame_timeout", 32'd0, 32'd1);
    chk("byte_cnt_end", byte_cnt, len);
    @(negedge clk);
    chk("done_single_pulse", done, 1'b0);
    chk("busy_after_frame", busy, 1'b0);
  endtask

  typedef struct {
    logic       mode;
    logic [7:0] seed;
    logic [7:0] din;
    logic [7:0] dout;
  } vec_t;

  vec_t       vecs[8];
  logic [7:0] orig[$];
  logic [7:0] saved[$];
  bit         done_seen;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1'b0, 8'hAC, 8'h00, 8'h7F};
    vecs[1] = '{1'b1, 8'hAC, 8'h7F, 8'h00};
    vecs[2] = '{1'b0, 8'h59, 8'h00, 8'hDC};
    vecs[3] = '{1'b1, 8'h59, 8'hDC, 8'h00};
    vecs[4] = '{1'b0, 8'hB3, 8'h00, 8'h2E};
    vecs[5] = '{1'b0, 8'h00, 8'hFF, 8'hBB};
    vecs[6] = '{1'b1, 8'h00, 8'hBB, 8'hFF};
    vecs[7] = '{1'b0, 8'hFF, 8'hFF, 8'h66};

    rst = 1'b1; start = 1'b0; cfg_mode = 1'b0; cfg_seed = 8'h00; cfg_len = '0;
    bus.s_valid = 1'b0; bus.s_data = 8'h00; bus.m_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_m_valid", bus.m_valid, 1'b0);
    chk("rst_m_data", bus.m_data, 8'h00);
    chk("rst_m_last", bus.m_last, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_byte_cnt", byte_cnt, 0);
    chk("rst_lfsr", dut.lfsr_q, 8'hAC);
    rst = 1'b0;
    @(negedge clk);
    bus.s_valid = 1'b1; #1;
    chk("idle_s_ready", bus.s_ready, 1'b0);
    bus.s_valid = 1'b0;

    // single-byte vectors
    for (int i = 0; i < 8; i++) begin
      frame_data.delete(); frame_data.push_back(vecs[i].din);
      run_frame(vecs[i].mode, vecs[i].seed, 1, 100, 100, -10, 1'b0);
      chk($sformatf("vec%0d", i), (got_data.size() > 0) ? got_data[0] : 8'hxx, vecs[i].dout);
    end

    // encrypt with reset seed, len 3
    frame_data = '{8'h00, 8'h00, 8'h00};
    run_frame(1'b0, 8'hAC, 3, 100, 100, -10, 1'b0);
    chk("enc3_n", got_data.size(), 3);
    if (got_data.size() == 3) begin
      chk("enc3_b0", got_data[0], 8'h7F);
      chk("enc3_b1", got_data[1], 8'hDC);
      chk("enc3_b2", got_data[2], 8'h2E);
      chk("enc3_last", {got_last[0], got_last[1], got_last[2]}, 3'b001);
    end

    // decrypt len 2
    frame_data = '{8'h7F, 8'hDC};
    run_frame(1'b1, 8'hAC, 2, 100, 100, -10, 1'b0);
    chk("dec2_n", got_data.size(), 2);
    if (got_data.size() == 2) begin
      chk("dec2_b0", got_data[0], 8'h00);
      chk("dec2_b1", got_data[1], 8'h00);
    end

    // random 256-byte round trip with random handshakes
    frame_data.delete();
    for (int i = 0; i < 256; i++) frame_data.push_back(8'($urandom));
    orig = frame_data;
    run_frame(1'b0, 8'h5A, 256, 60, 60, -10, 1'b0);
    frame_data = got_data;
    while (frame_data.size() < 256) frame_data.push_back(8'h00);
    run_frame(1'b1, 8'h5A, 256, 70, 50, -10, 1'b0);
    chk("rt_n", got_data.size(), 256);
    for (int i = 0; i < 256 && i < got_data.size(); i++)
      chk($sformatf("rt_b%0d", i), got_data[i], orig[i]);

    // backpressure: same frame with and without a 5-cycle stall
    frame_data = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    run_frame(1'b0, 8'h9D, 6, 100, 100, -10, 1'b0);
    saved = got_data;
    run_frame(1'b0, 8'h9D, 6, 100, 100, 2, 1'b0);
    chk("bp_n", got_data.size(), saved.size());
    for (int i = 0; i < saved.size() && i < got_data.size(); i++)
      chk($sformatf("bp_b%0d", i), got_data[i], saved[i]);

    // zero length
    @(negedge clk);
    start = 1'b1; cfg_len = '0; cfg_seed = 8'h42; bus.s_valid = 1'b1; bus.m_ready = 1'b1;
    #1 chk("zl_s_ready0", bus.s_ready, 1'b0);
    @(negedge clk);
    start = 1'b0;
    chk("zl_busy", busy, 1'b1);
    chk("zl_done", done, 1'b1);
    chk("zl_m_valid", bus.m_valid, 1'b0);
    chk("zl_s_ready1", bus.s_ready, 1'b0);
    @(negedge clk);
    chk("zl_busy_end", busy, 1'b0);
    chk("zl_done_end", done, 1'b0);
    chk("zl_m_valid_end", bus.m_valid, 1'b0);
    bus.s_valid = 1'b0;

    // start held during the frame is ignored
    frame_data.delete();
    for (int i = 0; i < 10; i++) frame_data.push_back(8'($urandom));
    run_frame(1'b1, 8'h37, 10, 80, 80, -10, 1'b1);
    chk("js_n", got_data.size(), 10);

    // reset mid-frame
    @(negedge clk);
    start = 1'b1; cfg_mode = 1'b0; cfg_seed = 8'h3C; cfg_len = LEN_W'(5);
    @(negedge clk);
    start = 1'b0; bus.s_valid = 1'b1; bus.m_ready = 1'b1; bus.s_data = 8'h12;
    repeat (2) @(negedge clk);
    chk("pre_rst_m_valid", bus.m_valid, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("mrst_m_valid", bus.m_valid, 1'b0);
    chk("mrst_m_data", bus.m_data, 8'h00);
    chk("mrst_m_last", bus.m_last, 1'b0);
    chk("mrst_busy", busy, 1'b0);
    chk("mrst_done", done, 1'b0);
    chk("mrst_byte_cnt", byte_cnt, 0);
    chk("mrst_s_ready", bus.s_ready, 1'b0);
    chk("mrst_lfsr", dut.lfsr_q, 8'hAC);
    bus.s_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    done_seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (done) done_seen = 1'b1;
    end
    chk("mrst_no_done", done_seen, 1'b0);
    frame_data = '{8'h00, 8'h00, 8'h00};
    run_frame(1'b0, 8'hAC, 3, 100, 100, -10, 1'b0);
    if (got_data.size() == 3) begin
      chk("post_rst_b0", got_data[0], 8'h7F);
      chk("post_rst_b1", got_data[1], 8'hDC);
      chk("post_rst_b2", got_data[2], 8'h2E);
    end else begin
      chk("post_rst_n", got_data.size(), 3);
    end

    // throughput: full rate, len 8
    frame_data.delete();
    for (int i = 0; i < 8; i++) frame_data.push_back(8'($urandom));
    run_frame(1'b0, 8'hE1, 8, 100, 100, -10, 1'b0);
    chk("tp_out_n", out_cyc.size(), 8);
    chk("tp_in_n", in_cyc.size(), 8);
    for (int i = 0; i < 8 && i < out_cyc.size() && i < in_cyc.size(); i++) begin
      chk($sformatf("tp_in_cyc%0d", i), in_cyc[i], i);
      chk($sformatf("tp_out_cyc%0d", i), out_cyc[i], in_cyc[i] + 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/crypto_stream_ctrl.md
Name: crypto_stream_ctrl

Overview:
- Frame-level sequencer for the byte cipher datapath: LFSR keystream, XOR, rotate-by-1 and 4-bit S-box.
- Accepts a frame of `cfg_len` bytes on a valid/ready input stream and applies the encrypt or decrypt transform with a keystream reseeded per frame.
- Emits a registered valid/ready output stream with an end-of-frame flag.
- Sits between the host byte interface and downstream framing logic; replaces free-running `enable` control of the keystream with per-byte advance.

Parameters:
- LEN_W, 16, width of the frame-length and byte counters.
- SEED_DEFAULT, 8'hAC, LFSR value after reset.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- start  in  1  one-cycle frame start request; honoured only in IDLE
- cfg_mode  in  1  0 = encrypt, 1 = decrypt; sampled on accepted start
- cfg_seed  in  8  LFSR seed; sampled on accepted start
- cfg_len  in  LEN_W  frame length in bytes; sampled on accepted start
- s_valid  in  1  input byte valid
- s_ready  out  1  input byte ready
- s_data  in  8  input byte
- m_valid  out  1  output byte valid
- m_ready  in  1  downstream ready
- m_data  out  8  transformed byte
- m_last  out  1  marks the final byte of the frame
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at frame completion
- byte_cnt  out  LEN_W  bytes accepted in the current frame

Behaviour:
- Reset values:
  - lfsr = SEED_DEFAULT; state = IDLE.
  - All outputs 0, including m_data and byte_cnt.
  - Reset mid-frame aborts the frame; no done pulse.
- LFSR step: `next = {lfsr[6:0], lfsr[7]^lfsr[6]^lfsr[5]^lfsr[4]^lfsr[3]}`. Steps only on an input handshake.
- Key for frame byte i is the seed stepped i times; byte 0 uses the seed.
- Encrypt: `x = d ^ k`, rotate left by 1, then S-box on each nibble.
- Decrypt: inverse S-box on each nibble, rotate right by 1, then XOR with k.
- S-box 0..F maps to 6,4,C,5,0,7,2,E,1,F,3,D,8,A,9,B. The inverse S-box is the exact inverse of this table.
- States:
  - IDLE: s_ready = 0, busy = 0.
    - start with cfg_len != 0: latch cfg_mode and cfg_len, lfsr <= cfg_seed, byte_cnt <= 0, go to RUN.
    - start with cfg_len == 0: go to FIN; nothing is emitted.
  - RUN: s_ready = !m_valid | m_ready (no bubble, 1 byte/cycle). On an input handshake:
    - m_data <= xform(s_data, lfsr, mode); m_valid <= 1.
    - m_last <= (byte_cnt == len-1).
    - lfsr steps; byte_cnt increments.
    - If this was the last byte, go to DRAIN.
    - With m_ready high and no new input, m_valid <= 0.
  - DRAIN: s_ready = 0. When m_valid & m_ready, clear m_valid and m_last, go to FIN.
  - FIN: done = 1 for exactly one cycle, then go to IDLE. The lfsr holds its last value until the next start.
- Latency is 1 cycle from input handshake to m_valid.
- m_data, m_last and m_valid hold stable while m_valid & !m_ready.
- start outside IDLE is ignored. s_valid outside RUN is ignored and not consumed.
- byte_cnt saturates at len; the frame never accepts more than len bytes.

Decomposition:
- Package crypto_pkg:
  - sbox and inv_sbox nibble functions.
  - lfsr_next function.
  - SEED_DEFAULT constant.
  - State enum {IDLE, RUN, DRAIN, FIN}.
- Sub-module crypto_byte_xform: combinational (d, key, mode) -> out, encrypt/decrypt selected by mode.
- FSM, LFSR, counter and output register live in the top.

Test Plan:
- Encrypt, reset seed: start, mode 0, seed 0xAC, len 3, input 00,00,00 with m_ready = 1 → m_data 7F, DC, then the third byte with key 0xB3; m_last on the third byte only; done pulses 1 cycle after the last output handshake.
- Decrypt round trip: mode 1, seed 0xAC, len 2, input 7F, DC → output 00, 00. A random 256-byte frame encrypted then decrypted with the same seed returns the original bytes.
- Backpressure: m_ready held low for 5 cycles mid-frame → s_ready low, m_data stable, lfsr frozen; the output sequence equals the no-stall run.
- Zero length: start with cfg_len 0 → busy for 1 cycle, done pulse, m_valid never asserts, s_ready stays 0.
- Ignored start and reset: start asserted during RUN has no effect on the frame. rst asserted mid-frame → all outputs 0 and lfsr = 0xAC next cycle, no done; a fresh frame then behaves as in the first scenario.
- Throughput: len 8, s_valid and m_ready constantly high → 8 output bytes on 8 consecutive cycles, first byte 1 cycle after the first input handshake.
